// File: rtl/arb_pkg.sv
// Shared types for the dual-port RAM read/write arbiter: requester tags,
// pipeline-stage record and the starvation counter width.
package arb_pkg;

  typedef enum logic [1:0] {
    REQ_VID = 2'd0,
    REQ_CPU = 2'd1,
    REQ_SPR = 2'd2
  } tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } stage_t;

  localparam stage_t      STAGE_IDLE = '{valid: 1'b0, tag: REQ_VID};
  localparam int unsigned WAIT_W     = 8;

endpackage

// File: rtl/starve_ctr.sv
// Per-requester wait counter; flags the requester as starved on the cycle
// that would be its STARVE_MAX-th consecutive wait.
module starve_ctr
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic grant_i,
  output logic starved_o
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(STARVE_MAX);
  localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || grant_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed waits; the current cycle is wait number cnt_q+1.
  assign starved_o = req_i && (cnt_q >= CNT_MAX - CNT_ONE);

endmodule

// File: rtl/dpram_arbiter.sv
// Three-requester pipelined read arbiter plus two-requester write arbiter
// in front of a synchronous dual-port RAM.
module dpram_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_ack,
  output logic          spr_rvalid,
  output logic [DW-1:0] spr_rdata,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_waddr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_wack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_ce_n,
  output logic          ram_oe_n,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata
);

  logic          cpu_starved, spr_starved;
  logic          gnt_vid, gnt_cpu, gnt_spr;
  tag_t          rr_q, rr_d;
  stage_t        a_q, a_d, d_q;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [2:0]    ack_q, rvalid_q, rvalid_d;
  logic          ce_n_q;
  logic [DW-1:0] vid_rdata_q, cpu_rdata_q, spr_rdata_q;
  logic          we_q, we_d, wack_q, wack_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_cpu_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (cpu_req),
    .grant_i   (gnt_cpu),
    .starved_o (cpu_starved)
  );

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_spr_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (spr_req),
    .grant_i   (gnt_spr),
    .starved_o (spr_starved)
  );

  // Starved cpu/spr outrank vid; otherwise vid first, then the round-robin pair.
  always_comb begin
    gnt_vid = 1'b0;
    gnt_cpu = 1'b0;
    gnt_spr = 1'b0;
    if (cpu_starved && spr_starved) begin
      gnt_cpu = (rr_q == REQ_CPU);
      gnt_spr = (rr_q != REQ_CPU);
    end else if (cpu_starved || spr_starved) begin
      gnt_cpu = cpu_starved;
      gnt_spr = spr_starved;
    end else if (vid_req) begin
      gnt_vid = 1'b1;
    end else if (cpu_req && spr_req) begin
      gnt_cpu = (rr_q == REQ_CPU);
      gnt_spr = (rr_q != REQ_CPU);
    end else begin
      gnt_cpu = cpu_req;
      gnt_spr = spr_req;
    end
  end

  always_comb begin
    a_d        = STAGE_IDLE;
    ram_addr_d = ram_addr_q;
    rr_d       = rr_q;
    if (gnt_vid) begin
      a_d        = '{valid: 1'b1, tag: REQ_VID};
      ram_addr_d = vid_addr;
    end else if (gnt_cpu) begin
      a_d        = '{valid: 1'b1, tag: REQ_CPU};
      ram_addr_d = cpu_addr;
      rr_d       = REQ_SPR;
    end else if (gnt_spr) begin
      a_d        = '{valid: 1'b1, tag: REQ_SPR};
      ram_addr_d = spr_addr;
      rr_d       = REQ_CPU;
    end
  end

  always_comb begin
    rvalid_d = '0;
    if (d_q.valid) begin
      rvalid_d[d_q.tag] = 1'b1;
    end
  end

  // cpu writes are unconditional; dma only proceeds when cpu is idle.
  always_comb begin
    we_d    = cpu_we || dma_we;
    wack_d  = dma_we && !cpu_we;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (cpu_we) begin
      waddr_d = cpu_waddr;
      wdata_d = cpu_wdata;
    end else if (dma_we) begin
      waddr_d = dma_waddr;
      wdata_d = dma_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= REQ_CPU;
      a_q         <= STAGE_IDLE;
      d_q         <= STAGE_IDLE;
      ram_addr_q  <= '0;
      ack_q       <= '0;
      ce_n_q      <= 1'b1;
      rvalid_q    <= '0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      spr_rdata_q <= '0;
      we_q        <= 1'b0;
      wack_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      rr_q        <= rr_d;
      a_q         <= a_d;
      d_q         <= a_q;
      ram_addr_q  <= ram_addr_d;
      ack_q       <= {gnt_spr, gnt_cpu, gnt_vid};
      ce_n_q      <= !a_q.valid;
      rvalid_q    <= rvalid_d;
      if (rvalid_d[REQ_VID]) vid_rdata_q <= ram_dout;
      if (rvalid_d[REQ_CPU]) cpu_rdata_q <= ram_dout;
      if (rvalid_d[REQ_SPR]) spr_rdata_q <= ram_dout;
      we_q        <= we_d;
      wack_q      <= wack_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign vid_ack    = ack_q[REQ_VID];
  assign cpu_ack    = ack_q[REQ_CPU];
  assign spr_ack    = ack_q[REQ_SPR];
  assign vid_rvalid = rvalid_q[REQ_VID];
  assign cpu_rvalid = rvalid_q[REQ_CPU];
  assign spr_rvalid = rvalid_q[REQ_SPR];
  assign vid_rdata  = vid_rdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign spr_rdata  = spr_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_ce_n   = ce_n_q;
  assign ram_oe_n   = ce_n_q;
  assign ram_we     = we_q;
  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign dma_wack   = wack_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural synchronous RAM that
// drives a poison value whenever ce_n/oe_n are not both low.
module tb_dpram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam logic [DW-1:0] POISON = 8'hEE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vid_req, cpu_req, spr_req;
  logic [AW-1:0] vid_addr, cpu_addr, spr_addr;
  logic          vid_ack, cpu_ack, spr_ack;
  logic          vid_rvalid, cpu_rvalid, spr_rvalid;
  logic [DW-1:0] vid_rdata, cpu_rdata, spr_rdata;
  logic          cpu_we, dma_we, dma_wack;
  logic [AW-1:0] cpu_waddr, dma_waddr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic [AW-1:0] ram_addr, ram_waddr;
  logic          ram_ce_n, ram_oe_n, ram_we;
  logic [DW-1:0] ram_dout, ram_wdata;

  int n_vec = 0;
  int n_err = 0;

  dpram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack),
    .spr_rvalid(spr_rvalid), .spr_rdata(spr_rdata),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .dma_we(dma_we), .dma_waddr(dma_waddr), .dma_wdata(dma_wdata),
    .dma_wack(dma_wack),
    .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_dout(ram_dout), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;

  // Read captures the pre-write contents when both ports hit one address.
  always @(posedge clk) begin
    rd_q <= mem[ram_addr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end
  assign ram_dout = (ram_ce_n || ram_oe_n) ? POISON : rd_q;

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [2:0] onehot(input byte e);
    case (e)
      "V":     return 3'b100;
      "C":     return 3'b010;
      "S":     return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Each char of seq is the grant expected at successive edges; rvalid/rdata
  // are checked two edges later. Requests drop after the last grant.
  task automatic run(input string tag, input string seq);
    byte           gq[$];
    logic [15:0]   aq[$];
    byte           e, old;
    logic [15:0]   ga, oa;
    gq.push_back("-"); gq.push_back("-");
    aq.push_back(16'h0); aq.push_back(16'h0);
    for (int i = 0; i < seq.len() + 2; i++) begin
      if (i == seq.len()) begin
        vid_req = 1'b0; cpu_req = 1'b0; spr_req = 1'b0;
      end
      e  = (i < seq.len()) ? seq[i] : 8'h2D;
      ga = (e == "V") ? vid_addr : (e == "C") ? cpu_addr : spr_addr;
      tick();
      check($sformatf("%s ack[%0d]", tag, i), {vid_ack, cpu_ack, spr_ack}, onehot(e));
      if (e != "-") check($sformatf("%s ram_addr[%0d]", tag, i), ram_addr, ga);
      gq.push_back(e);
      aq.push_back(ga);
      check($sformatf("%s ce_n[%0d]", tag, i), ram_ce_n, (gq[1] == "-"));
      old = gq.pop_front();
      oa  = aq.pop_front();
      check($sformatf("%s rvalid[%0d]", tag, i), {vid_rvalid, cpu_rvalid, spr_rvalid}, onehot(old));
      case (old)
        "V": check($sformatf("%s vid_rdata[%0d]", tag, i), vid_rdata, f(oa));
        "C": check($sformatf("%s cpu_rdata[%0d]", tag, i), cpu_rdata, f(oa));
        "S": check($sformatf("%s spr_rdata[%0d]", tag, i), spr_rdata, f(oa));
        default: ;
      endcase
      if (vid_ack) vid_addr++;
      if (cpu_ack) cpu_addr++;
      if (spr_ack) spr_addr++;
    end
  endtask

  task automatic read_one(input string tag, input byte who, input logic [15:0] a,
                          input logic [7:0] d);
    if (who == "C") begin cpu_req = 1'b1; cpu_addr = a; end
    else if (who == "S") begin spr_req = 1'b1; spr_addr = a; end
    else begin vid_req = 1'b1; vid_addr = a; end
    tick();
    check({tag, " ack"}, {vid_ack, cpu_ack, spr_ack}, onehot(who));
    vid_req = 1'b0; cpu_req = 1'b0; spr_req = 1'b0;
    tick();
    tick();
    check({tag, " rvalid"}, {vid_rvalid, cpu_rvalid, spr_rvalid}, onehot(who));
    check({tag, " rdata"}, (who == "C") ? cpu_rdata : (who == "S") ? spr_rdata : vid_rdata, d);
  endtask

  initial begin
    vid_req = 0; cpu_req = 0; spr_req = 0;
    vid_addr = '0; cpu_addr = '0; spr_addr = '0;
    cpu_we = 0; dma_we = 0;
    cpu_waddr = '0; dma_waddr = '0; cpu_wdata = '0; dma_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = f(16'(i));
    mem[16'h1234] = 8'h5A;
    mem[16'h0030] = 8'h00;

    repeat (2) @(negedge clk);
    check("reset acks", {vid_ack, cpu_ack, spr_ack}, 3'b000);
    check("reset rvalids", {vid_rvalid, cpu_rvalid, spr_rvalid}, 3'b000);
    check("reset ce_n/oe_n", {ram_ce_n, ram_oe_n}, 2'b11);
    check("reset we/wack", {ram_we, dma_wack}, 2'b00);
    check("reset ram_addr", ram_addr, 16'h0000);
    check("reset rdata", {vid_rdata, cpu_rdata, spr_rdata}, 24'h0);

    // Single cpu read issued on the first edge after reset release.
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    tick();
    check("single ack", {vid_ack, cpu_ack, spr_ack}, 3'b010);
    check("single ram_addr", ram_addr, 16'h1234);
    check("single ce_n E0", ram_ce_n, 1'b1);
    cpu_req = 1'b0;
    tick();
    check("single ack gone", {vid_ack, cpu_ack, spr_ack}, 3'b000);
    check("single ce/oe E1", {ram_ce_n, ram_oe_n}, 2'b00);
    check("single rvalid early", cpu_rvalid, 1'b0);
    tick();
    check("single rvalid", cpu_rvalid, 1'b1);
    check("single rdata", cpu_rdata, 8'h5A);
    check("single ce_n E2", ram_ce_n, 1'b1);
    tick();
    check("single rvalid off", cpu_rvalid, 1'b0);
    check("single rdata hold", cpu_rdata, 8'h5A);

    // The cpu grant above left the pointer favouring spr.
    cpu_req = 1'b1; cpu_addr = 16'h0200;
    spr_req = 1'b1; spr_addr = 16'h0300;
    run("rr", "SCSCS");

    // All three continuous: 7 vid grants, then both starved -> cpu, spr.
    vid_req = 1'b1; vid_addr = 16'h0100;
    cpu_req = 1'b1; cpu_addr = 16'h0210;
    spr_req = 1'b1; spr_addr = 16'h0310;
    run("starve", "VVVVVVVCSVVVVVVCS");

    // cpu loses to vid, then abandons its request.
    vid_req = 1'b1; vid_addr = 16'h0400;
    cpu_req = 1'b1; cpu_addr = 16'h0500;
    tick();
    check("abandon ack", {vid_ack, cpu_ack, spr_ack}, 3'b100);
    vid_req = 1'b0; cpu_req = 1'b0;
    tick();
    check("abandon ack2", {vid_ack, cpu_ack, spr_ack}, 3'b000);
    check("abandon rvalid2", {vid_rvalid, cpu_rvalid, spr_rvalid}, 3'b000);
    tick();
    check("abandon rvalid3", {vid_rvalid, cpu_rvalid, spr_rvalid}, 3'b100);
    check("abandon vid_rdata", vid_rdata, 8'h58);
    tick();
    check("abandon rvalid4", {vid_rvalid, cpu_rvalid, spr_rvalid}, 3'b000);

    // Simultaneous cpu and dma writes.
    cpu_we = 1'b1; cpu_waddr = 16'h0010; cpu_wdata = 8'h11;
    dma_we = 1'b1; dma_waddr = 16'h0020; dma_wdata = 8'h22;
    tick();
    check("wr cpu we/wack", {ram_we, dma_wack}, 2'b10);
    check("wr cpu waddr", ram_waddr, 16'h0010);
    check("wr cpu wdata", ram_wdata, 8'h11);
    cpu_we = 1'b0;
    tick();
    check("wr dma we/wack", {ram_we, dma_wack}, 2'b11);
    check("wr dma waddr", ram_waddr, 16'h0020);
    check("wr dma wdata", ram_wdata, 8'h22);
    dma_we = 1'b0;
    tick();
    check("wr idle we/wack", {ram_we, dma_wack}, 2'b00);
    read_one("rb10", "S", 16'h0010, 8'h11);
    read_one("rb20", "S", 16'h0020, 8'h22);

    // Read and write to one address granted on the same edge.
    cpu_req = 1'b1; cpu_addr = 16'h0030;
    cpu_we = 1'b1; cpu_waddr = 16'h0030; cpu_wdata = 8'hAA;
    tick();
    check("rw ack", {vid_ack, cpu_ack, spr_ack}, 3'b010);
    check("rw we", ram_we, 1'b1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    tick();
    check("rw rvalid", cpu_rvalid, 1'b1);
    check("rw old data", cpu_rdata, 8'h00);
    read_one("rw new", "C", 16'h0030, 8'hAA);

    // Reset asserted while the read is in flight.
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    tick();
    check("rst ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    tick();
    check("rst ce_n before", ram_ce_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst async ce/oe", {ram_ce_n, ram_oe_n}, 2'b11);
    check("rst async ram_addr", ram_addr, 16'h0000);
    check("rst async cpu_rdata", cpu_rdata, 8'h00);
    check("rst async acks", {vid_ack, cpu_ack, spr_ack, vid_rvalid, cpu_rvalid, spr_rvalid}, 6'h0);
    @(negedge clk);
    check("rst held rvalid", cpu_rvalid, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rst after rvalid1", cpu_rvalid, 1'b0);
    tick();
    check("rst after rvalid2", cpu_rvalid, 1'b0);
    check("rst after ce_n", ram_ce_n, 1'b1);
    read_one("post rst", "C", 16'h1234, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
